// File: rtl/scm_read_stream_ctrl_if.sv
// Bundles the burst command, SCM read port and output stream of the read controller.
// master = controller side, slave = surrounding datapath / SCM side.
interface scm_read_stream_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [ADDR_WIDTH-1:0] cmd_len_i;
    logic                  flush_i;
    logic                  mem_ren_o;
    logic [ADDR_WIDTH-1:0] mem_raddr_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_last_o;
    logic                  busy_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, flush_i, mem_rdata_i, out_ready_i,
        output cmd_ready_o, mem_ren_o, mem_raddr_o, out_valid_o, out_data_o, out_last_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, flush_i, mem_rdata_i, out_ready_i,
        input  cmd_ready_o, mem_ren_o, mem_raddr_o, out_valid_o, out_data_o, out_last_o, busy_o
    );
endinterface

// File: rtl/scm_read_stream_ctrl.sv
// Burst read controller for a 1R1W SCM: issues reads and streams words with last flag.
// Latency cmd->first word 3 cycles; issue throttled by buffer credit so stalls never drop data.
module scm_read_stream_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    scm_read_stream_ctrl_if.master bus
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state, stateNext;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic                  inflight;
    logic                  inflightLast;

    logic [DATA_WIDTH-1:0] bufData [OUT_DEPTH];
    logic                  bufLast [OUT_DEPTH];
    logic [PTR_W-1:0]      wrPtr, rdPtr;
    logic [CNT_W-1:0]      count;

    logic                  cmdFire, pop, push, memRen;
    logic [CNT_W:0]        occupancy;

    assign cmdFire = (state == IDLE) && bus.cmd_valid_i && !bus.flush_i;
    assign pop     = bus.out_valid_o && bus.out_ready_i;
    assign push    = inflight;

    // Credit check counts the read already in flight and the slot freed by this cycle's pop.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);

    always_comb begin
        stateNext = state;
        memRen    = 1'b0;
        case (state)
            IDLE: begin
                if (cmdFire) stateNext = ISSUE;
            end
            ISSUE: begin
                memRen = occupancy < (CNT_W+1)'(OUT_DEPTH);
                if (memRen && remaining == '0) stateNext = DRAIN;
            end
            DRAIN: begin
                if (pop && bus.out_last_o) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (bus.flush_i) begin
            stateNext = IDLE;
            memRen    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr         <= '0;
            remaining    <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
        end else begin
            inflight     <= memRen;
            inflightLast <= memRen && (remaining == '0);
            if (cmdFire) begin
                addr      <= bus.cmd_addr_i;
                remaining <= bus.cmd_len_i;
            end else if (memRen) begin
                addr <= addr + ADDR_WIDTH'(1);
                if (remaining != '0) remaining <= remaining - ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (bus.flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= (wrPtr == PTR_W'(OUT_DEPTH-1)) ? '0 : wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= (rdPtr == PTR_W'(OUT_DEPTH-1)) ? '0 : rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by count.
    always_ff @(posedge clk) begin
        if (push && !bus.flush_i) begin
            bufData[wrPtr] <= bus.mem_rdata_i;
            bufLast[wrPtr] <= inflightLast;
        end
    end

    assign bus.cmd_ready_o = (state == IDLE);
    assign bus.busy_o      = (state != IDLE);
    assign bus.mem_ren_o   = memRen;
    assign bus.mem_raddr_o = addr;
    assign bus.out_valid_o = (count != '0);
    assign bus.out_data_o  = (count != '0) ? bufData[rdPtr] : '0;
    assign bus.out_last_o  = (count != '0) ? bufLast[rdPtr] : 1'b0;
endmodule

// File: tb/tb_scm_read_stream_ctrl.sv
// Directed bench for scm_read_stream_ctrl with a behavioural registered-read SCM.
module tb_scm_read_stream_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    scm_read_stream_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    scm_read_stream_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .OUT_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(int a);
        return 32'hD00D_0000 + 32'((a % 32) * 3 + 1);
    endfunction

    // Registered-read SCM model.
    always @(posedge clk) if (bus.mem_ren_o) bus.mem_rdata_i <= memval(int'(bus.mem_raddr_o));

    logic [4:0]  renQ [$];
    logic [32:0] popQ [$];
    always @(posedge clk) begin
        if (!rst && bus.mem_ren_o) renQ.push_back(bus.mem_raddr_o);
        if (!rst && !bus.flush_i && bus.out_valid_o && bus.out_ready_i)
            popQ.push_back({bus.out_last_o, bus.out_data_o});
    end

    task automatic send_cmd(input int a, input int l);
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = 5'(a);
        bus.cmd_len_i   = 5'(l);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy_o && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.busy_o) begin
            failures++;
            $display("FAIL %s timeout: busy still %b after %0d cycles", name, bus.busy_o, n);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bus.cmd_ready_o, bus.mem_ren_o, bus.out_valid_o, bus.out_last_o, bus.busy_o} !== 5'b10000
            || bus.mem_raddr_o !== 5'd0 || bus.out_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy/ren/vld/last/busy=%b raddr=%0d data=%h want 10000 0 0",
                     {bus.cmd_ready_o, bus.mem_ren_o, bus.out_valid_o, bus.out_last_o, bus.busy_o},
                     bus.mem_raddr_o, bus.out_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.mem_ren_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%b busy=%b ren=%b want 1 0 0",
                     bus.cmd_ready_o, bus.busy_o, bus.mem_ren_o);
        end
    endtask

    // addr=3 len=3: cycle-exact ren/addr/valid/data/last from c+1 to c+7.
    task automatic test_basic_burst;
        bus.out_ready_i = 1'b1;
        send_cmd(3, 3);
        for (int k = 1; k <= 7; k++) begin
            logic        eRen, eVld, eLast, eBusy;
            logic [4:0]  eAddr;
            logic [31:0] eData;
            if (k > 1) @(negedge clk);
            #1;
            eRen  = (k <= 4);
            eAddr = 5'(3 + k - 1);
            eVld  = (k >= 3 && k <= 6);
            eData = eVld ? memval(k) : 32'd0;
            eLast = (k == 6);
            eBusy = (k <= 6);
            checks++;
            if (bus.mem_ren_o !== eRen || (eRen && bus.mem_raddr_o !== eAddr) ||
                bus.out_valid_o !== eVld || bus.out_data_o !== eData ||
                bus.out_last_o !== eLast || bus.busy_o !== eBusy) begin
                failures++;
                $display("FAIL basic_c%0d got ren=%b addr=%0d vld=%b data=%h last=%b busy=%b want %b %0d %b %h %b %b",
                         k, bus.mem_ren_o, bus.mem_raddr_o, bus.out_valid_o, bus.out_data_o,
                         bus.out_last_o, bus.busy_o, eRen, eAddr, eVld, eData, eLast, eBusy);
            end
        end
    endtask

    task automatic test_wrap;
        int exp [5] = '{30, 31, 0, 1, 2};
        renQ.delete();
        popQ.delete();
        bus.out_ready_i = 1'b1;
        send_cmd(30, 4);
        wait_idle("wrap");
        checks++;
        if (renQ.size() != 5 || popQ.size() != 5) begin
            failures++;
            $display("FAIL wrap_count got issues=%0d words=%0d want 5 5", renQ.size(), popQ.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (renQ[i] !== 5'(exp[i]) || popQ[i] !== {(i == 4), memval(exp[i])}) begin
                    failures++;
                    $display("FAIL wrap_word%0d got addr=%0d word=%h want %0d %h",
                             i, renQ[i], popQ[i], exp[i], {(i == 4), memval(exp[i])});
                end
            end
        end
    endtask

    task automatic test_single;
        popQ.delete();
        bus.out_ready_i = 1'b1;
        send_cmd(9, 0);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (k == 3) begin
                checks++;
                if (bus.out_valid_o !== 1'b1 || bus.out_last_o !== 1'b1 || bus.out_data_o !== memval(9)) begin
                    failures++;
                    $display("FAIL single_word got vld=%b last=%b data=%h want 1 1 %h",
                             bus.out_valid_o, bus.out_last_o, bus.out_data_o, memval(9));
                end
            end
        end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || popQ.size() != 1) begin
            failures++;
            $display("FAIL single_after got busy=%b rdy=%b vld=%b words=%0d want 0 1 0 1",
                     bus.busy_o, bus.cmd_ready_o, bus.out_valid_o, popQ.size());
        end
    endtask

    task automatic test_random_ready;
        logic        stalled = 1'b0;
        logic [32:0] held = '0;
        int          n = 0;
        int          badStable = 0;
        popQ.delete();
        bus.out_ready_i = 1'b0;
        send_cmd(7, 31);
        while (n < 600) begin
            if (n > 0) @(negedge clk);
            bus.out_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (stalled && (bus.out_valid_o !== 1'b1 || {bus.out_last_o, bus.out_data_o} !== held))
                badStable++;
            stalled = bus.out_valid_o && !bus.out_ready_i;
            held    = {bus.out_last_o, bus.out_data_o};
            n++;
            if (!bus.busy_o) break;
        end
        checks++;
        if (badStable != 0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL random_stable got unstable_cycles=%0d busy=%b want 0 0", badStable, bus.busy_o);
        end
        checks++;
        if (popQ.size() != 32) begin
            failures++;
            $display("FAIL random_count got %0d words want 32", popQ.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (popQ[i] !== {(i == 31), memval(7 + i)}) begin
                    failures++;
                    $display("FAIL random_word%0d got %h want %h", i, popQ[i], {(i == 31), memval(7 + i)});
                end
            end
        end
    endtask

    task automatic test_stall;
        renQ.delete();
        popQ.delete();
        bus.out_ready_i = 1'b1;
        send_cmd(0, 15);
        repeat (4) @(negedge clk);
        bus.out_ready_i = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (bus.mem_ren_o !== 1'b0 || bus.out_valid_o !== 1'b1 || renQ.size() != popQ.size() + 2) begin
            failures++;
            $display("FAIL stall_hold got ren=%b vld=%b issued=%0d popped=%0d want 0 1 popped+2",
                     bus.mem_ren_o, bus.out_valid_o, renQ.size(), popQ.size());
        end
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.mem_ren_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_resume got ren=%b want 1", bus.mem_ren_o);
        end
        wait_idle("stall");
        checks++;
        if (popQ.size() != 16 || popQ[15] !== {1'b1, memval(15)} || popQ[6] !== {1'b0, memval(6)}) begin
            failures++;
            $display("FAIL stall_words got n=%0d w6=%h w15=%h want 16 %h %h",
                     popQ.size(), popQ[6], popQ[15], {1'b0, memval(6)}, {1'b1, memval(15)});
        end
    endtask

    task automatic test_flush;
        int n = 0;
        popQ.delete();
        bus.out_ready_i = 1'b1;
        send_cmd(10, 15);
        #1;
        while (popQ.size() < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        bus.flush_i     = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = 5'd0;
        bus.cmd_len_i   = 5'd0;
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.cmd_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mem_ren_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_state got vld=%b busy=%b ren=%b rdy=%b want 0 0 0 1",
                     bus.out_valid_o, bus.busy_o, bus.mem_ren_o, bus.cmd_ready_o);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (popQ.size() != 3 || bus.busy_o !== 1'b0 || popQ[2] !== {1'b0, memval(12)}) begin
            failures++;
            $display("FAIL flush_quiet got words=%0d busy=%b w2=%h want 3 0 %h",
                     popQ.size(), bus.busy_o, popQ[2], {1'b0, memval(12)});
        end
        popQ.delete();
        send_cmd(20, 1);
        wait_idle("flush_next");
        checks++;
        if (popQ.size() != 2 || popQ[0] !== {1'b0, memval(20)} || popQ[1] !== {1'b1, memval(21)}) begin
            failures++;
            $display("FAIL flush_next got n=%0d w0=%h w1=%h want 2 %h %h",
                     popQ.size(), popQ[0], popQ[1], {1'b0, memval(20)}, {1'b1, memval(21)});
        end
    endtask

    task automatic test_reset_mid_burst;
        popQ.delete();
        bus.out_ready_i = 1'b1;
        send_cmd(5, 10);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.cmd_ready_o, bus.mem_ren_o, bus.out_valid_o, bus.out_last_o, bus.busy_o} !== 5'b10000
            || bus.mem_raddr_o !== 5'd0 || bus.out_data_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid got rdy/ren/vld/last/busy=%b raddr=%0d data=%h want 10000 0 0",
                     {bus.cmd_ready_o, bus.mem_ren_o, bus.out_valid_o, bus.out_last_o, bus.busy_o},
                     bus.mem_raddr_o, bus.out_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        popQ.delete();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (popQ.size() != 0 || bus.out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_quiet got words=%0d vld=%b want 0 0", popQ.size(), bus.out_valid_o);
        end
        send_cmd(2, 2);
        wait_idle("rst_next");
        checks++;
        if (popQ.size() != 3 || popQ[0] !== {1'b0, memval(2)} || popQ[2] !== {1'b1, memval(4)}) begin
            failures++;
            $display("FAIL rst_next got n=%0d w0=%h w2=%h want 3 %h %h",
                     popQ.size(), popQ[0], popQ[2], {1'b0, memval(2)}, {1'b1, memval(4)});
        end
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_len_i   = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        test_reset();
        test_basic_burst();
        test_wrap();
        test_single();
        test_random_ready();
        test_stall();
        test_flush();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
